// File: rtl/multicycle_ctrl_fsm_if.sv
// Memory request/acknowledge bundle between the multi-cycle controller
// (master) and the memory subsystem (slave).
interface multicycle_ctrl_fsm_if;
  logic mem_req;       // request, held until ack or timeout
  logic mem_we;        // write strobe, qualifies mem_req
  logic mem_addr_sel;  // 0 = PC, 1 = ALU result
  logic mem_ack;       // memory completes the current request this cycle

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ack
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM for the 16-instruction core.
// Sequences FETCH/DECODE/EXEC/MEM/WB/BRANCH and drives PC, IR, register-file,
// ALU and memory controls. Memory accesses use a req/ack handshake with a
// bounded wait; a stalled request raises a one-cycle mem_err and re-fetches.
//
// Opcode map (IR[15:12]):
//   0000 shift (func 01 shl, 10 shr, 11 sar, 00 illegal)
//   0001 lwd       0010 strwd     0011 jmp
//   0100 brncheq   0101 brnchneq  0110 addseimd  0111 subseimd
//   1000 add       1001 sub       1010 nand      1011 or
//   1100 addzeimd  1101 lnandimd  1110 lorimd    1111 subzeimd
//
// Optional feature: define RETIRE_CNT_EN to add the 16-bit retired_cnt
// output counting normally completed instructions.
module multicycle_ctrl_fsm #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  multicycle_ctrl_fsm_if.master  mem,
  input  logic [3:0]             opcode,
  input  logic [1:0]             func,
  input  logic                   zero_flag,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic [1:0]             pc_src,
  output logic [2:0]             alu_op,
  output logic [1:0]             alu_src_b,
  output logic                   rf_we,
  output logic                   illegal,
  output logic                   mem_err,
  output logic [2:0]             state
`ifdef RETIRE_CNT_EN
  ,
  output logic [15:0]            retired_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    BRANCH = 3'd6
  } state_t;

  localparam logic [3:0] OP_SHIFT  = 4'b0000;
  localparam logic [3:0] OP_LWD    = 4'b0001;
  localparam logic [3:0] OP_STRWD  = 4'b0010;
  localparam logic [3:0] OP_JMP    = 4'b0011;
  localparam logic [3:0] OP_BEQ    = 4'b0100;
  localparam logic [3:0] OP_BNE    = 4'b0101;
  localparam logic [3:0] OP_ADDSE  = 4'b0110;
  localparam logic [3:0] OP_SUBSE  = 4'b0111;
  localparam logic [3:0] OP_ADD    = 4'b1000;
  localparam logic [3:0] OP_SUB    = 4'b1001;
  localparam logic [3:0] OP_NAND   = 4'b1010;
  localparam logic [3:0] OP_OR     = 4'b1011;
  localparam logic [3:0] OP_ADDZE  = 4'b1100;
  localparam logic [3:0] OP_NANDZE = 4'b1101;
  localparam logic [3:0] OP_ORZE   = 4'b1110;
  localparam logic [3:0] OP_SUBZE  = 4'b1111;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_NAND = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SHL  = 3'd4;

  localparam logic [1:0] SRC_REG  = 2'd0;
  localparam logic [1:0] SRC_SEXT = 2'd1;
  localparam logic [1:0] SRC_ZEXT = 2'd2;

  localparam logic [1:0] PC_PLUS2  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_req_c, mem_we_c, mem_addr_sel_c;

  // State and memory-wait counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and Moore output decode; the counter is zero outside
  // FETCH/MEM, so every entry into a memory state starts a fresh wait.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = '0;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    pc_src         = PC_PLUS2;
    alu_op         = ALU_ADD;
    alu_src_b      = SRC_REG;
    rf_we          = 1'b0;
    illegal        = 1'b0;
    mem_err        = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        mem_req_c = 1'b1;
        if (mem.mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_PLUS2;
          state_d  = DECODE;
        end else if (wait_cnt_q == MAX_WAIT_C) begin
          // Abandon the fetch; PC is untouched so the retry reads the same word.
          mem_err = 1'b1;
          state_d = FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      DECODE: begin
        case (opcode)
          OP_JMP: begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
            state_d  = FETCH;
          end
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_SHIFT: begin
            if (func == 2'b00) begin
              illegal = 1'b1;
              state_d = FETCH;
            end else begin
              state_d = EXEC;
            end
          end
          default: state_d = EXEC;
        endcase
      end

      EXEC: begin
        case (opcode)
          OP_SHIFT: begin
            alu_op    = ALU_SHL + {1'b0, func} - 3'd1;
            alu_src_b = SRC_REG;
          end
          OP_LWD, OP_STRWD, OP_ADDSE: begin
            alu_op    = ALU_ADD;
            alu_src_b = SRC_SEXT;
          end
          OP_SUBSE: begin
            alu_op    = ALU_SUB;
            alu_src_b = SRC_SEXT;
          end
          OP_ADD:    alu_op = ALU_ADD;
          OP_SUB:    alu_op = ALU_SUB;
          OP_NAND:   alu_op = ALU_NAND;
          OP_OR:     alu_op = ALU_OR;
          OP_ADDZE: begin
            alu_op    = ALU_ADD;
            alu_src_b = SRC_ZEXT;
          end
          OP_NANDZE: begin
            alu_op    = ALU_NAND;
            alu_src_b = SRC_ZEXT;
          end
          OP_ORZE: begin
            alu_op    = ALU_OR;
            alu_src_b = SRC_ZEXT;
          end
          OP_SUBZE: begin
            alu_op    = ALU_SUB;
            alu_src_b = SRC_ZEXT;
          end
          default: begin
            alu_op    = ALU_ADD;
            alu_src_b = SRC_REG;
          end
        endcase
        state_d = (opcode == OP_LWD || opcode == OP_STRWD) ? MEM : WB;
      end

      MEM: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b1;
        mem_we_c       = (opcode == OP_STRWD);
        if (mem.mem_ack) begin
          state_d = (opcode == OP_STRWD) ? FETCH : WB;
        end else if (wait_cnt_q == MAX_WAIT_C) begin
          mem_err = 1'b1;
          state_d = FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      WB: begin
        rf_we   = 1'b1;
        state_d = FETCH;
      end

      BRANCH: begin
        alu_op    = ALU_SUB;
        alu_src_b = SRC_REG;
        if ((opcode == OP_BEQ && zero_flag) || (opcode == OP_BNE && !zero_flag)) begin
          pc_write = 1'b1;
          pc_src   = PC_BRANCH;
        end
        state_d = FETCH;
      end

      default: state_d = IDLE;
    endcase
  end

  assign mem.mem_req      = mem_req_c;
  assign mem.mem_we       = mem_we_c;
  assign mem.mem_addr_sel = mem_addr_sel_c;
  assign state            = state_q;

`ifdef RETIRE_CNT_EN
  logic        retire;
  logic [15:0] retired_cnt_q, retired_cnt_d;

  // An instruction retires on a normal return to FETCH; illegal and timeout
  // exits are excluded (MEM only returns to FETCH on ack for strwd).
  always_comb begin
    retire = (state_d == FETCH) &&
             ((state_q == WB) || (state_q == BRANCH) ||
              (state_q == MEM && mem.mem_ack) ||
              (state_q == DECODE && opcode == OP_JMP));
    retired_cnt_d = retire ? retired_cnt_q + 16'd1 : retired_cnt_q;
  end

  // Retired-instruction counter register, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) retired_cnt_q <= '0;
    else          retired_cnt_q <= retired_cnt_d;
  end

  assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: each instruction is planned as a
// per-cycle list of inputs and expected outputs, then replayed against the DUT.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] opcode;
  logic [1:0] func;
  logic       zero_flag;
  logic       ir_write, pc_write, rf_we, illegal, mem_err;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op, dut_state;
`ifdef RETIRE_CNT_EN
  logic [15:0] retired_cnt;
`endif

  multicycle_ctrl_fsm_if mif ();

  multicycle_ctrl_fsm #(.WAIT_W(4), .MAX_WAIT(15)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem       (mif),
    .opcode    (opcode),
    .func      (func),
    .zero_flag (zero_flag),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .alu_op    (alu_op),
    .alu_src_b (alu_src_b),
    .rf_we     (rf_we),
    .illegal   (illegal),
    .mem_err   (mem_err),
    .state     (dut_state)
`ifdef RETIRE_CNT_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int exp_retire = 0;

  logic [7:0]  stim_q[$];  // {opcode, func, zero_flag, mem_ack}
  logic [17:0] exp_q[$];
  string       tag_q[$];

  // EXEC expectations per opcode (shift computed from func separately).
  logic [2:0] aop_tab [16] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1,
                               3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd2, 3'd3, 3'd1};
  logic [1:0] sb_tab  [16] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1,
                               2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2};

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [17:0] ev(input logic [2:0] st, input logic req, input logic we,
                                     input logic asel, input logic irw, input logic pcw,
                                     input logic [1:0] pcs, input logic [2:0] aop,
                                     input logic [1:0] sb, input logic rf, input logic ill,
                                     input logic err);
    return {st, req, we, asel, irw, pcw, pcs, aop, sb, rf, ill, err};
  endfunction

  function automatic logic [17:0] observed();
    return {dut_state, mif.mem_req, mif.mem_we, mif.mem_addr_sel, ir_write, pc_write,
            pc_src, alu_op, alu_src_b, rf_we, illegal, mem_err};
  endfunction

  task automatic push(input logic [3:0] op, input logic [1:0] fn, input logic zf,
                      input logic ack, input string tag, input logic [17:0] e);
    stim_q.push_back({op, fn, zf, ack});
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // FETCH with dly unacked cycles (dly <= 15); opcode is garbage meanwhile.
  task automatic plan_fetch(input int dly, input string nm);
    for (int i = 0; i < dly; i++)
      push(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'b0, 1'b0,
           {nm, "_fetch_wait"}, ev(3'd1, 1, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 0, 0, 0));
    push(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'b0, 1'b1,
         {nm, "_fetch_ack"}, ev(3'd1, 1, 0, 0, 1, 1, 2'd0, 3'd0, 2'd0, 0, 0, 0));
  endtask

  task automatic plan_fetch_timeout(input string nm);
    for (int i = 0; i < 16; i++)
      push(4'($urandom_range(0, 15)), 2'd0, 1'b0, 1'b0, {nm, "_fetch_to"},
           ev(3'd1, 1, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 0, 0, (i == 15)));
  endtask

  // Whole instruction; mdly > 15 means memory never answers in MEM.
  task automatic plan_instr(input logic [3:0] op, input logic [1:0] fn, input logic zf,
                            input int fdly, input int mdly, input string nm);
    logic       taken, we;
    logic [2:0] aop;
    plan_fetch(fdly, nm);
    if (op == 4'd3) begin
      push(op, fn, zf, 1'b1, {nm, "_decode"}, ev(3'd2, 0, 0, 0, 0, 1, 2'd2, 3'd0, 2'd0, 0, 0, 0));
      exp_retire++;
      return;
    end
    if (op == 4'd0 && fn == 2'd0) begin
      push(op, fn, zf, 1'b1, {nm, "_decode"}, ev(3'd2, 0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 0, 1, 0));
      return;
    end
    push(op, fn, zf, 1'b1, {nm, "_decode"}, ev(3'd2, 0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 0, 0, 0));
    if (op == 4'd4 || op == 4'd5) begin
      taken = (op == 4'd4) ? zf : !zf;
      push(op, fn, zf, 1'b1, {nm, "_branch"},
           ev(3'd6, 0, 0, 0, 0, taken, taken ? 2'd1 : 2'd0, 3'd1, 2'd0, 0, 0, 0));
      exp_retire++;
      return;
    end
    aop = (op == 4'd0) ? (3'd3 + {1'b0, fn}) : aop_tab[op];
    push(op, fn, zf, 1'b1, {nm, "_exec"}, ev(3'd3, 0, 0, 0, 0, 0, 2'd0, aop, sb_tab[op], 0, 0, 0));
    if (op == 4'd1 || op == 4'd2) begin
      we = (op == 4'd2);
      if (mdly > 15) begin
        for (int i = 0; i < 16; i++)
          push(op, fn, zf, 1'b0, {nm, "_mem_to"},
               ev(3'd4, 1, we, 1, 0, 0, 2'd0, 3'd0, 2'd0, 0, 0, (i == 15)));
        return;
      end
      for (int i = 0; i < mdly; i++)
        push(op, fn, zf, 1'b0, {nm, "_mem_wait"}, ev(3'd4, 1, we, 1, 0, 0, 2'd0, 3'd0, 2'd0, 0, 0, 0));
      push(op, fn, zf, 1'b1, {nm, "_mem_ack"}, ev(3'd4, 1, we, 1, 0, 0, 2'd0, 3'd0, 2'd0, 0, 0, 0));
      if (we) begin
        exp_retire++;
        return;
      end
    end
    push(op, fn, zf, 1'b1, {nm, "_wb"}, ev(3'd5, 0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 1, 0, 0));
    exp_retire++;
  endtask

  // Replay: drive just after the rising edge, compare on the falling edge.
  task automatic run_queue();
    logic [7:0] s;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      {opcode, func, zero_flag, mif.mem_ack} = s;
      @(negedge clk);
      check(tag_q.pop_front(), observed(), exp_q.pop_front());
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    opcode      = 4'd0;
    func        = 2'd0;
    zero_flag   = 1'b0;
    mif.mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", observed(), 18'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    push(4'd0, 2'd0, 1'b0, 1'b1, "idle", 18'd0);
    plan_instr(4'b1000, 2'd0, 1'b0, 0, 0, "add");
    plan_instr(4'b0001, 2'd0, 1'b0, 0, 3, "lwd_late");
    plan_instr(4'b0010, 2'd0, 1'b0, 1, 0, "strwd");
    plan_instr(4'b0100, 2'd0, 1'b1, 0, 0, "beq_taken");
    plan_instr(4'b0101, 2'd0, 1'b1, 0, 0, "bne_not");
    plan_instr(4'b0101, 2'd0, 1'b0, 2, 0, "bne_taken");
    plan_instr(4'b0100, 2'd0, 1'b0, 0, 0, "beq_not");
    plan_instr(4'b0011, 2'd0, 1'b0, 0, 0, "jmp");
    plan_instr(4'b0000, 2'd0, 1'b0, 0, 0, "shift_ill");
    plan_instr(4'b0000, 2'd1, 1'b0, 0, 0, "shl");
    plan_instr(4'b0000, 2'd2, 1'b0, 1, 0, "shr");
    plan_instr(4'b0000, 2'd3, 1'b0, 0, 0, "sar");
    for (int op = 6; op < 16; op++)
      plan_instr(4'(op), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), 0, $sformatf("alu%0d", op));
    plan_fetch_timeout("timeout");
    plan_instr(4'b1001, 2'd0, 1'b0, 0, 0, "after_to");
    plan_instr(4'b1000, 2'd0, 1'b0, 15, 0, "ack_at_max");
    plan_instr(4'b0001, 2'd0, 1'b0, 0, 15, "lwd_mem_max");
    plan_instr(4'b0001, 2'd0, 1'b0, 0, 16, "lwd_mem_to");
    plan_instr(4'b0010, 2'd0, 1'b0, 0, 2, "strwd_late");
    run_queue();
    $display("retired instructions planned: %0d", exp_retire);
`ifdef RETIRE_CNT_EN
    check("retired_cnt", 18'(retired_cnt), 18'(exp_retire));
`endif

    // Asynchronous reset in the middle of a MEM stall.
    plan_fetch(0, "rst");
    push(4'b0001, 2'd0, 1'b0, 1'b0, "rst_decode", ev(3'd2, 0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 0, 0, 0));
    push(4'b0001, 2'd0, 1'b0, 1'b0, "rst_exec", ev(3'd3, 0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd1, 0, 0, 0));
    push(4'b0001, 2'd0, 1'b0, 1'b0, "rst_mem", ev(3'd4, 1, 0, 1, 0, 0, 2'd0, 3'd0, 2'd0, 0, 0, 0));
    run_queue();
    opcode      = 4'b0001;
    mif.mem_ack = 1'b0;
    #2;
    check("mem_req_before_rst", 18'(mif.mem_req), 18'd1);
    reset_n = 1'b0;
    #1;
    check("mem_req_async_rst", 18'(mif.mem_req), 18'd0);
    check("state_async_rst", 18'(dut_state), 18'd0);
    repeat (2) @(posedge clk);
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
